// File: rtl/pipe_csel_adder.sv
// pipe_csel_adder: pipelined carry-select adder/subtractor, one BLOCK_W-bit block resolved per stage
//   clock_i      rising-edge clock
//   reset_n_i    asynchronous active-low reset
//   in_valid_i   operand beat offered          in_ready_o   stage 0 can accept
//   in_a_i       operand A                     in_b_i       operand B
//   in_sub_i     1: A - B (in_cin_i ignored)   in_cin_i     carry-in for add
//   out_valid_o  result valid                  out_ready_i  consumer accepts result
//   out_sum_o    result                        out_cout_o   carry out of MSB (sub: 1 = no borrow)
//   out_ovf_o    signed overflow
//   Define PIPE_CSEL_SAT_EN to clamp out_sum_o to signed max/min on overflow.
module pipe_csel_adder #(
   parameter int WIDTH   = 32,
   parameter int BLOCK_W = 8
) (
   input  logic             clock_i,
   input  logic             reset_n_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_a_i,
   input  logic [WIDTH-1:0] in_b_i,
   input  logic             in_sub_i,
   input  logic             in_cin_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_sum_o,
   output logic             out_cout_o,
   output logic             out_ovf_o
);
   localparam int NBLK = WIDTH / BLOCK_W;
   // the last stage needs no operand registers
   localparam int NOPS = (NBLK > 1) ? NBLK - 1 : 1;
   localparam logic [NBLK-1:0] ONES = '1;
`ifdef PIPE_CSEL_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   if (NBLK < 1 || WIDTH % BLOCK_W != 0) begin : g_param_err
      $error("pipe_csel_adder: WIDTH must be a non-zero multiple of BLOCK_W");
   end

   logic [NBLK-1:0]  v_q, v_d, adv, ld, c_q, c_d, cin_blk;
   logic [NBLK:0]    free;
   logic [WIDTH-1:0] s_q [NBLK];
   logic [WIDTH-1:0] s_d [NBLK];
   logic [WIDTH-1:0] sp  [NBLK];
   logic [WIDTH-1:0] a_d [NBLK];
   logic [WIDTH-1:0] b_d [NBLK];
   logic [WIDTH-1:0] a_q [NOPS];
   logic [WIDTH-1:0] b_q [NOPS];
   logic [BLOCK_W:0] cand0 [NBLK];
   logic [BLOCK_W:0] cand1 [NBLK];
   logic [BLOCK_W:0] sel   [NBLK];
   logic             ovf_q, ovf_d, msb_cin;

   always_comb begin
      // stage k may move if any stage at or after it is empty, or the consumer takes the result
      for (int k = 0; k <= NBLK; k++) free[k] = out_ready_i | ((v_q >> k) != (ONES >> k));
      for (int k = 0; k < NBLK; k++) adv[k] = v_q[k] & free[k+1];
      ld = (adv << 1) | NBLK'(in_valid_i & free[0]);
      v_d = ld | (v_q & ~adv);
      a_d[0] = in_a_i;
      b_d[0] = in_sub_i ? ~in_b_i : in_b_i;
      sp[0] = '0;
      cin_blk = '0;
      cin_blk[0] = in_sub_i | in_cin_i;
      for (int k = 1; k < NBLK; k++) begin
         a_d[k] = a_q[k-1];
         b_d[k] = b_q[k-1];
         sp[k] = s_q[k-1];
         cin_blk[k] = c_q[k-1];
      end
      c_d = '0;
      for (int k = 0; k < NBLK; k++) begin
         cand0[k] = {1'b0, a_d[k][k*BLOCK_W +: BLOCK_W]} + {1'b0, b_d[k][k*BLOCK_W +: BLOCK_W]};
         cand1[k] = {1'b0, a_d[k][k*BLOCK_W +: BLOCK_W]} + {1'b0, b_d[k][k*BLOCK_W +: BLOCK_W]} + (BLOCK_W+1)'(1);
         sel[k] = cin_blk[k] ? cand1[k] : cand0[k];
         s_d[k] = sp[k];
         s_d[k][k*BLOCK_W +: BLOCK_W] = sel[k][BLOCK_W-1:0];
         c_d[k] = sel[k][BLOCK_W];
      end
      // carry into the MSB recovered from its sum bit
      msb_cin = a_d[NBLK-1][WIDTH-1] ^ b_d[NBLK-1][WIDTH-1] ^ s_d[NBLK-1][WIDTH-1];
      ovf_d = c_d[NBLK-1] ^ msb_cin;
      // on overflow both operands share A's sign, which picks the clamp direction
      s_d[NBLK-1] = (SAT_EN && ovf_d) ? (a_d[NBLK-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                              : {1'b0, {(WIDTH-1){1'b1}}})
                                      : s_d[NBLK-1];
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         v_q <= '0;
         c_q <= '0;
         ovf_q <= 1'b0;
         for (int k = 0; k < NBLK; k++) s_q[k] <= '0;
         for (int k = 0; k < NOPS; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
         end
      end else begin
         v_q <= v_d;
         if (ld[NBLK-1]) ovf_q <= ovf_d;
         for (int k = 0; k < NBLK; k++) begin
            if (ld[k]) begin
               s_q[k] <= s_d[k];
               c_q[k] <= c_d[k];
            end
         end
         for (int k = 0; k < NBLK - 1; k++) begin
            if (ld[k]) begin
               a_q[k] <= a_d[k];
               b_q[k] <= b_d[k];
            end
         end
      end
   end

   assign in_ready_o  = free[0];
   assign out_valid_o = v_q[NBLK-1];
   assign out_sum_o   = s_q[NBLK-1];
   assign out_cout_o  = c_q[NBLK-1];
   assign out_ovf_o   = ovf_q;
endmodule

// File: tb/tb_pipe_csel_adder.sv
// tb_pipe_csel_adder: directed table-driven bench for pipe_csel_adder (WIDTH=32, BLOCK_W=8)
module tb_pipe_csel_adder;
   localparam int LAT = 4;
`ifdef PIPE_CSEL_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic        cin;
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        in_valid = 1'b0, in_ready, in_sub = 1'b0, in_cin = 1'b0;
   logic [31:0] in_a = '0, in_b = '0, out_sum;
   logic        out_valid, out_ready = 1'b1, out_cout, out_ovf;
   int          errors = 0, checks = 0;
   vec_t        tbl [13];
   logic [33:0] q [$];

   pipe_csel_adder #(.WIDTH(32), .BLOCK_W(8)) dut (
      .clock_i(clk), .reset_n_i(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_a_i(in_a), .in_b_i(in_b), .in_sub_i(in_sub), .in_cin_i(in_cin),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_sum_o(out_sum), .out_cout_o(out_cout), .out_ovf_o(out_ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // reference: {ovf, cout, sum}
   function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic cin);
      logic [31:0] be, s;
      logic [32:0] f;
      logic        ov;
      be = sub ? ~b : b;
      f = {1'b0, a} + {1'b0, be} + 33'(sub ? 1'b1 : cin);
      s = f[31:0];
      ov = (a[31] == be[31]) && (s[31] != a[31]);
      if (SAT && ov) s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return {ov, f[32], s};
   endfunction

   task automatic run_vec(input int i);
      int n;
      @(negedge clk);
      in_a = tbl[i].a; in_b = tbl[i].b; in_sub = tbl[i].sub; in_cin = tbl[i].cin;
      in_valid = 1'b1; out_ready = 1'b1;
      #1 chk($sformatf("vec%0d in_ready", i), in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 12) begin
         @(posedge clk);
         #1 n++;
      end
      chk($sformatf("vec%0d latency", i), n, LAT);
      chk($sformatf("vec%0d sum", i), out_sum, tbl[i].sum);
      chk($sformatf("vec%0d cout", i), out_cout, tbl[i].cout);
      chk($sformatf("vec%0d ovf", i), out_ovf, tbl[i].ovf);
      @(posedge clk);
   endtask

   initial begin
      tbl[0]  = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
      tbl[1]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      tbl[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1};
      tbl[3]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
      tbl[4]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1};
      tbl[5]  = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      tbl[6]  = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
      tbl[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, SAT ? 32'h8000_0000 : 32'h0000_0000, 1'b1, 1'b1};
      tbl[8]  = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0};
      tbl[9]  = '{32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1'b1, 32'h0001_FFFF, 1'b0, 1'b0};
      tbl[10] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      tbl[11] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1};
      tbl[12] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      #1;
      chk("reset out_valid", out_valid, 0);
      chk("reset in_ready", in_ready, 1);
      chk("reset out_sum", out_sum, 0);
      chk("reset out_cout", out_cout, 0);
      chk("reset out_ovf", out_ovf, 0);

      for (int i = 0; i < 13; i++) run_vec(i);

      // back-to-back stream with a 3-cycle consumer stall
      begin
         int sent = 0, got = 0, cyc = 0;
         logic hold = 1'b0, blocked = 1'b0, hc = 1'b0, ho = 1'b0;
         logic [31:0] hs = '0;
         logic [31:0] sa [8];
         logic [31:0] sb [8];
         logic [33:0] e;
         for (int i = 0; i < 8; i++) begin
            sa[i] = 32'h89AB_CDEF + 32'h1357_9BDF * i;
            sb[i] = 32'h7654_3210 ^ (32'h1111_1111 * i);
         end
         while (got < 8 && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= 5 && cyc <= 7);
            in_valid = sent < 8;
            if (sent < 8) begin
               in_a = sa[sent]; in_b = sb[sent]; in_sub = sent[0]; in_cin = sent[1];
            end
            #1;
            if (hold) begin
               chk($sformatf("stall c%0d valid", cyc), out_valid, 1);
               chk($sformatf("stall c%0d sum", cyc), out_sum, hs);
               chk($sformatf("stall c%0d cout", cyc), out_cout, hc);
               chk($sformatf("stall c%0d ovf", cyc), out_ovf, ho);
            end
            if (in_valid && !in_ready) blocked = 1'b1;
            if (out_valid && out_ready) begin
               e = (q.size() > 0) ? q.pop_front() : 34'h3_FFFF_FFFF;
               chk($sformatf("stream%0d result", got), {out_ovf, out_cout, out_sum}, e);
               got++;
            end
            hold = out_valid && !out_ready;
            hs = out_sum; hc = out_cout; ho = out_ovf;
            if (in_valid && in_ready) begin
               q.push_back(model(in_a, in_b, in_sub, in_cin));
               sent++;
            end
            cyc++;
         end
         chk("stream count", got, 8);
         chk("stream in_ready dropped", blocked, 1);
         @(negedge clk) in_valid = 1'b0;
         out_ready = 1'b1;
      end

      // reset with beats in flight
      begin
         int stale = 0;
         @(negedge clk);
         out_ready = 1'b0; in_valid = 1'b1; in_sub = 1'b0; in_cin = 1'b0;
         in_a = 32'h1111_1111; in_b = 32'h2222_2222;
         repeat (5) @(negedge clk);
         chk("inflight out_valid", out_valid, 1);
         chk("inflight out_sum", out_sum, 32'h3333_3333);
         #2 rst_n = 1'b0;
         in_valid = 1'b0;
         #1;
         chk("midreset out_valid", out_valid, 0);
         chk("midreset out_sum", out_sum, 0);
         chk("midreset out_cout", out_cout, 0);
         @(negedge clk) rst_n = 1'b1;
         out_ready = 1'b1;
         #1 chk("postreset in_ready", in_ready, 1);
         repeat (10) begin
            @(negedge clk);
            if (out_valid) stale++;
         end
         chk("postreset stale beats", stale, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
